// File: rtl/song_sequencer.sv
// Song sequencer: walks a song BRAM of {duration, note} words and drives the tone generator.
// Optional macro SONG_SEQ_NOTE_GAP_EN inserts GAP_TICKS cycles of silence after every note.
module song_sequencer #(
    parameter int TICKS_PER_BEAT = 3125000,
    parameter int ADDR_W         = 4,
    parameter int GAP_TICKS      = 312500
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Play,
    output logic [ADDR_W-1:0] o_ROM_Addr,
    input  logic [11:0]       i_ROM_Data,
    output logic [7:0]        o_Note,
    output logic              o_Note_Valid,
    output logic              o_Busy,
    output logic [2:0]        o_State
);

    localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PLAY  = 3'd3
`ifdef SONG_SEQ_NOTE_GAP_EN
        , S_GAP = 3'd4
`endif
    } state_t;

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [3:0]          r_beat_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_note;
    logic                r_note_valid;
    logic [3:0]          w_duration;
    logic                w_beat_end;

`ifdef SONG_SEQ_NOTE_GAP_EN
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
    logic [GAP_W-1:0]    r_gap_cnt;
`else
    // Silence length is irrelevant without the gap, but a nonsense value is still rejected.
    if (GAP_TICKS < 1) begin : g_bad_gap_ticks
        $error("GAP_TICKS must be at least 1");
    end
`endif

    if (TICKS_PER_BEAT < 1) begin : g_bad_ticks
        $error("TICKS_PER_BEAT must be at least 1");
    end

    assign w_duration = i_ROM_Data[11:8];
    assign w_beat_end = (r_tick_cnt == TICK_LAST);

    // Stop and reset share one path: IDLE always holds the cleared values, so
    // i_Play=0 while already idle is harmless.
    always_ff @(posedge i_Clk) begin
        r_note_valid <= 1'b0;
        if (i_Rst || !i_Play) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_note     <= 8'h00;
            r_tick_cnt <= '0;
            r_beat_cnt <= 4'd0;
`ifdef SONG_SEQ_NOTE_GAP_EN
            r_gap_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    if (w_duration != 4'd0) begin
                        r_note       <= i_ROM_Data[7:0];
                        r_note_valid <= 1'b1;
                        r_beat_cnt   <= w_duration;
                        r_tick_cnt   <= '0;
                        r_state      <= S_PLAY;
                    end else begin
                        r_addr  <= '0;
                        r_note  <= 8'h00;
                        r_state <= S_FETCH;
                    end
                end
                S_PLAY: begin
                    if (w_beat_end) begin
                        r_tick_cnt <= '0;
                        r_beat_cnt <= r_beat_cnt - 4'd1;
                        if (r_beat_cnt == 4'd1) begin
                            r_addr <= r_addr + ADDR_W'(1);
`ifdef SONG_SEQ_NOTE_GAP_EN
                            r_note    <= 8'h00;
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
`else
                            r_state <= S_FETCH;
`endif
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                    end
                end
`ifdef SONG_SEQ_NOTE_GAP_EN
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_FETCH;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ROM_Addr   = r_addr;
    assign o_Note       = r_note;
    assign o_Note_Valid = r_note_valid;
    assign o_Busy       = (r_state != S_IDLE);
    assign o_State      = r_state;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: hand-derived vector table, directed stop/reset/marker sequences,
// and randomized songs checked cycle by cycle against a song-walking trace model.
module tb_song_sequencer;

    localparam int TPB   = 4;
    localparam int GAPT  = 2;
    localparam int AW    = 2;
    localparam int ROM_N = 1 << AW;
    localparam int EXP_W = AW + 8 + 2;

`ifdef SONG_SEQ_NOTE_GAP_EN
    localparam int STOP_AT   = 16;
    localparam int A_CYCLES  = 25;
`else
    localparam int STOP_AT   = 14;
    localparam int A_CYCLES  = 21;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          play;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data;
    logic [7:0]    note;
    logic          note_valid;
    logic          busy;
    logic [2:0]    dbg_state;

    logic [11:0]      rom [ROM_N];
    logic [EXP_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int pulses = 0;

    typedef struct {
        logic [11:0]   w0, w1, w2, w3;
        int            k;
        logic [AW-1:0] addr;
        logic [7:0]    nt;
        logic          valid;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    song_sequencer #(
        .TICKS_PER_BEAT(TPB),
        .ADDR_W(AW),
        .GAP_TICKS(GAPT)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Play(play),
        .o_ROM_Addr(rom_addr),
        .i_ROM_Data(rom_data),
        .o_Note(note),
        .o_Note_Valid(note_valid),
        .o_Busy(busy),
        .o_State(dbg_state)
    );

    function automatic logic [EXP_W-1:0] obs();
        return {rom_addr, note, note_valid, busy};
    endfunction

    task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got addr=%0d note=%02h valid=%0b busy=%0b, expected addr=%0d note=%02h valid=%0b busy=%0b",
                     name, $time, act[EXP_W-1:10], act[9:2], act[1], act[0],
                     exp[EXP_W-1:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void push_exp(input int a, input logic [7:0] nt, input logic v);
        exp_q.push_back({AW'(a), nt, v, 1'b1});
    endfunction

    // Expected output per cycle after i_Play rises from IDLE: fetch/latch of the
    // current word, then the note held for duration*TPB cycles, then the next word.
    task automatic build_trace(input int n);
        int a;
        int d;
        logic [7:0] nt;
        exp_q.delete();
        a  = 0;
        nt = 8'h00;
        push_exp(a, nt, 1'b0);
        push_exp(a, nt, 1'b0);
        while (exp_q.size() < n) begin
            d = int'(rom[a][11:8]);
            if (d == 0) begin
                a  = 0;
                nt = 8'h00;
            end else begin
                nt = rom[a][7:0];
                for (int i = 0; i < d * TPB; i++) push_exp(a, nt, i == 0);
                a = (a + 1) % ROM_N;
`ifdef SONG_SEQ_NOTE_GAP_EN
                nt = 8'h00;
                for (int i = 0; i < GAPT; i++) push_exp(a, nt, 1'b0);
`endif
            end
            push_exp(a, nt, 1'b0);
            push_exp(a, nt, 1'b0);
        end
    endtask

    task automatic run(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            tick();
            if (note_valid === 1'b1) pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: model trace exhausted, got note=%02h", name, note);
            end else begin
                check(name, obs(), exp_q.pop_front());
            end
        end
    endtask

    task automatic reset_dut();
        rst  = 1'b1;
        play = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_idle", obs(), '0);
    endtask

    task automatic load_rom(input logic [11:0] w0, input logic [11:0] w1,
                            input logic [11:0] w2, input logic [11:0] w3);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    function automatic void add_vec(input logic [11:0] w0, input logic [11:0] w1,
                                    input logic [11:0] w2, input logic [11:0] w3,
                                    input int k, input logic [AW-1:0] a,
                                    input logic [7:0] nt, input logic v);
        vec_t r;
        r.w0 = w0; r.w1 = w1; r.w2 = w2; r.w3 = w3;
        r.k = k; r.addr = a; r.nt = nt; r.valid = v;
        vecs.push_back(r);
    endfunction

    initial begin
        rst  = 1'b1;
        play = 1'b0;
        load_rom(12'h000, 12'h000, 12'h000, 12'h000);

        // Hand-derived expectations: state of the outputs k cycles after i_Play rises.
`ifdef SONG_SEQ_NOTE_GAP_EN
        add_vec(12'h261, 12'h163, 12'h000, 12'h000,  3, 2'd0, 8'h61, 1'b1);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 10, 2'd0, 8'h61, 1'b0);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 11, 2'd1, 8'h00, 1'b0);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 12, 2'd1, 8'h00, 1'b0);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 15, 2'd1, 8'h63, 1'b1);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 25, 2'd0, 8'h61, 1'b1);
        add_vec(12'h000, 12'h111, 12'h122, 12'h133, 50, 2'd0, 8'h00, 1'b0);
`else
        add_vec(12'h261, 12'h163, 12'h000, 12'h000,  3, 2'd0, 8'h61, 1'b1);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 10, 2'd0, 8'h61, 1'b0);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 11, 2'd1, 8'h61, 1'b0);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 13, 2'd1, 8'h63, 1'b1);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 19, 2'd0, 8'h00, 1'b0);
        add_vec(12'h261, 12'h163, 12'h000, 12'h000, 21, 2'd0, 8'h61, 1'b1);
        add_vec(12'h111, 12'h122, 12'h133, 12'h144, 21, 2'd3, 8'h44, 1'b1);
        add_vec(12'h111, 12'h122, 12'h133, 12'h144, 25, 2'd0, 8'h44, 1'b0);
        add_vec(12'h111, 12'h122, 12'h133, 12'h144, 27, 2'd0, 8'h11, 1'b1);
        add_vec(12'h000, 12'h111, 12'h122, 12'h133, 50, 2'd0, 8'h00, 1'b0);
`endif
        @(negedge clk);

        foreach (vecs[v]) begin
            reset_dut();
            load_rom(vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3);
            build_trace(vecs[v].k + 4);
            play = 1'b1;
            run(vecs[v].k, "vec_trace");
            check($sformatf("vec%0d", v), obs(), {vecs[v].addr, vecs[v].nt, vecs[v].valid, 1'b1});
        end

        // One o_Note_Valid pulse per note across a full pass of the song.
        reset_dut();
        load_rom(12'h261, 12'h163, 12'h000, 12'h000);
        build_trace(A_CYCLES + 4);
        pulses = 0;
        play = 1'b1;
        run(A_CYCLES, "song_a_trace");
        check_int("song_a_pulses", pulses, 3);

        // Stop mid-note at address 1, then restart from address 0.
        reset_dut();
        build_trace(STOP_AT + 4);
        play = 1'b1;
        run(STOP_AT, "stop_trace");
        play = 1'b0;
        tick();
        check("stop_next_cycle", obs(), '0);
        tick();
        check("stop_idle_hold", obs(), '0);
        build_trace(10);
        play = 1'b1;
        run(6, "restart_trace");

        // Reset mid-note with i_Play held high.
        reset_dut();
        build_trace(20);
        play = 1'b1;
        run(6, "pre_reset_trace");
        rst = 1'b1;
        tick();
        check("reset_mid_note", obs(), '0);
        rst = 1'b0;
        build_trace(12);
        run(8, "post_reset_trace");

        // End marker at address 0: busy forever, silent, no pulses.
        reset_dut();
        load_rom(12'h000, 12'h261, 12'h163, 12'h111);
        build_trace(104);
        pulses = 0;
        play = 1'b1;
        run(100, "marker_loop_trace");
        check_int("marker_loop_pulses", pulses, 0);
        check("marker_loop_final", obs(), {AW'(0), 8'h00, 1'b0, 1'b1});

        // Random songs with random stop/reset points.
        for (int it = 0; it < 30; it++) begin
            reset_dut();
            for (int j = 0; j < ROM_N; j++)
                rom[j] = {4'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 3) != 0 && rom[0][11:8] == 4'd0) rom[0][11:8] = 4'd1;
            build_trace(200);
            play = 1'b1;
            run($urandom_range(5, 80), "rand_trace");
            if ($urandom_range(0, 1) == 1) begin
                play = 1'b0;
                tick();
                check("rand_stop", obs(), '0);
            end else begin
                rst = 1'b1;
                tick();
                check("rand_reset", obs(), '0);
                rst = 1'b0;
                build_trace(60);
                run($urandom_range(3, 30), "rand_restart_trace");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_BEAT, default 3125000, meaning i_Clk cycles per beat (125 ms at 25 MHz).
REQ-002 SHALL have parameter ADDR_W, default 4, meaning song ROM address width.
REQ-003 SHALL have parameter GAP_TICKS, default 312500, meaning the inter-note silence length in cycles (used only under REQ-024).
REQ-004 SHALL have port i_Clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_Rst, input, 1, meaning reset, which is synchronous and active-high.
REQ-006 SHALL have port i_Play, input, 1, meaning level run enable.
REQ-007 SHALL have port o_ROM_Addr, output, ADDR_W, meaning the song BRAM read address.
REQ-008 SHALL have port i_ROM_Data, input, 12, meaning a BRAM word with one-cycle read latency: [7:0] note code, [11:8] duration in beats, where duration 0 is the end marker.
REQ-009 SHALL have port o_Note, output, 8, meaning the current note code for the tone generator (8'h00 = rest).
REQ-010 SHALL have port o_Note_Valid, output, 1, meaning a one-cycle pulse when o_Note loads a ROM note.
REQ-011 SHALL have port o_Busy, output, 1, meaning high in any state other than IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, FETCH, LATCH, PLAY and GAP.
REQ-013 SHALL, in IDLE with i_Play=1, go to FETCH on the next cycle; o_ROM_Addr holds its value through FETCH.
REQ-014 SHALL, in FETCH, go to LATCH unconditionally; i_ROM_Data is valid in LATCH.
REQ-015 SHALL, in LATCH with duration != 0, register o_Note <= data[7:0], pulse o_Note_Valid for one cycle, load beat_cnt <= duration, clear tick_cnt, and go to PLAY.
REQ-016 SHALL, in LATCH with duration == 0, set o_ROM_Addr <= 0, force o_Note <= 8'h00, and go to FETCH, with no o_Note_Valid pulse.
REQ-017 SHALL, in PLAY, count tick_cnt 0..TICKS_PER_BEAT-1; at terminal count it clears tick_cnt and decrements beat_cnt.
REQ-018 SHALL, when beat_cnt==1 and tick_cnt is at terminal count, advance o_ROM_Addr by 1 (mod 2^ADDR_W) and go to FETCH, or to GAP per REQ-024.
REQ-019 SHALL hold each note on o_Note for exactly duration*TICKS_PER_BEAT cycles in PLAY; the next note appears 2 cycles later (FETCH plus LATCH), during which the old note is held.
REQ-020 SHALL, when the address is 2^ADDR_W-1 and the note ends, wrap to address 0 with no end marker required.
REQ-021 SHALL, when i_Play=0 in any non-IDLE state, go to IDLE on the next edge with o_ROM_Addr <= 0, o_Note <= 8'h00, counters cleared, and o_Note_Valid low; stopping takes priority over all other transitions.
REQ-022 SHALL, when the word at address 0 is an end marker, loop FETCH/LATCH with o_Note=8'h00 and o_Busy=1 and no pulses.

Reset
REQ-023 SHALL, when i_Rst=1 at a clock edge (including mid-note), set state=IDLE, o_ROM_Addr=0, o_Note=8'h00, o_Note_Valid=0, o_Busy=0, and tick_cnt=beat_cnt=gap_cnt=0; reset takes priority over i_Play.

Configuration
REQ-024 SHALL support macro SONG_SEQ_NOTE_GAP_EN: when it is defined, note end goes to GAP with o_Note=8'h00 for GAP_TICKS cycles and then to FETCH; i_Play=0 in GAP follows REQ-021. When it is undefined, the GAP state and gap_cnt are not compiled and note end goes directly to FETCH.

Verification (TICKS_PER_BEAT=4, GAP_TICKS=2, ADDR_W=2)
REQ-025 SHALL cover this scenario: ROM {0x261,0x163,0x000,x}, i_Play=1 -> o_Note 0x61 for 8 cycles, then 0x63 for 4 cycles, then 0x00 for the end-marker refetch, then 0x61 again; o_Note_Valid pulses once per note.
REQ-026 SHALL cover this scenario: ROM has all four words with duration 1 -> the address sequence is 0,1,2,3,0 with a period of 6 cycles per note and wrap without a marker.
REQ-027 SHALL cover this scenario: i_Play dropped mid-PLAY at address 1 -> the next cycle shows o_Busy=0, o_Note=0x00, o_ROM_Addr=0; re-asserting restarts from address 0.
REQ-028 SHALL cover this scenario: i_Rst pulsed during PLAY with i_Play=1 held -> all outputs are at reset values on the following cycle; FETCH follows the cycle after i_Rst drops.
REQ-029 SHALL cover this scenario: SONG_SEQ_NOTE_GAP_EN defined with the ROM from REQ-025 -> two 0x00 cycles are inserted after each note before FETCH.
REQ-030 SHALL cover this scenario: address-0 word is 0x000 -> o_Busy=1, o_Note=0x00 and o_Note_Valid never pulses over 100 cycles.
